fpga_switch_loader: RTL and testbench
=====================================

// Module: fpga_switch_loader
// PURPOSE
//  Board-input counterpart of the LED display path: assembles a 32-bit word from the
//  16 board switches in two button-confirmed halves (high half first, then low half),
//  then offers it to the processor top over a valid/ready handshake. Used to inject
//  operands and register values without re-synthesis. Sits beside the top-level
//  board wrapper, in the same clock domain as the processor.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive stable cycles needed before the button level is accepted (>=1)
//  HALF_W           16  switch/half-word width; word width is 2*HALF_W
// PORTS
//  clk         in   1         system clock, all logic on posedge
//  rst         in   1         asynchronous, active-high reset
//  sw          in   HALF_W    raw board switches (asynchronous)
//  btn         in   1         raw "load" push button (asynchronous, bouncy)
//  word_ready  in   1         consumer accepts word this cycle
//  word_valid  out  1         word_data holds a complete word
//  word_data   out  2*HALF_W  assembled word {high, low}
//  phase       out  2         0=S_HIGH, 1=S_LOW, 2=S_VALID (drive spare LEDs)
//  led_out     out  HALF_W    synchronised switch value echoed for operator feedback
// BEHAVIOUR
//  Reset (async, rst=1): state S_HIGH, word_valid=0, word_data=0, phase=0, led_out=0,
//   sync flops, debounce counter and stable level all 0.
//  Input sync: sw and btn each pass through 2 flops; only synced values used downstream.
//  Debounce: stable level changes only after synced btn differs from it for
//   DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter.
//  press = 1-cycle pulse on stable 0->1; registered. Latency: btn held high from edge 0
//   -> press high after edge 2+DEBOUNCE_CYCLES+1. Release never pulses; holding btn
//   gives exactly one pulse.
//  FSM (phase mirrors state):
//   S_HIGH : press -> word_data[2W-1:W] <= synced sw, go S_LOW.
//   S_LOW  : press -> word_data[W-1:0] <= synced sw, go S_VALID; word_valid=1 next cycle.
//   S_VALID: word_valid=1, word_data frozen. word_valid&&word_ready -> word_valid=0,
//            go S_HIGH next cycle. Press ignored here, including in the transfer cycle.
//   encoding 3 unused: recover to S_HIGH, word_valid=0.
//  word_valid is registered and asserted only in S_VALID; never combinationally
//   dependent on word_ready. word_ready outside S_VALID has no effect.
//  word_data holds last captured halves at all times (not cleared on transfer);
//   high half of a new word overwrites only [2W-1:W] until low half arrives.
//  led_out = synced sw, updated every cycle (2-cycle lag from pins).
//  rst mid-operation: partial word discarded, all state returns to reset values.
// STRUCTURE
//  Shared package: phase encodings (PH_HIGH=2'd0, PH_LOW=2'd1, PH_VALID=2'd2),
//   default HALF_W=16.
//  Sub-module btn_debounce(clk, rst, raw, level, rise): 2-flop sync, counter of
//   $clog2(DEBOUNCE_CYCLES+1) bits, rise pulse; reused for future board buttons.
//  Top holds sw sync, FSM, word register, output regs.
// TESTING (DEBOUNCE_CYCLES=4 for sim)
//  1. sw=16'h1234, clean press; sw=16'hABCD, press -> word_valid=1, word_data=32'h1234ABCD,
//     phase 0->1->2; press rises exactly 7 edges after btn.
//  2. btn toggling every 2 cycles for 20 cycles then held 10 -> exactly one press pulse.
//  3. In S_VALID, word_ready=0 for 5 cycles plus extra press -> data/valid unchanged;
//     word_ready=1 -> word_valid=0 next edge, phase=0.
//  4. Press coincident with word_valid&&word_ready -> ignored; phase=0, word_data unchanged.
//  5. rst pulsed asynchronously between halves (phase=1) -> outputs at once 0; next two
//     presses build fresh word 32'h0000FFFF from sw=0 then sw=16'hFFFF.
//  6. Button held 50 cycles then released -> one pulse, none on release; led_out tracks sw.

Source files
------------

// File: rtl/fpga_switch_loader_pkg.sv
// Shared encodings for the switch loader: FSM states double as the phase code
// shown on the spare LEDs.
package fpga_switch_loader_pkg;

    localparam int HALF_W_DEFAULT = 16;

    localparam logic [1:0] PH_HIGH  = 2'd0;
    localparam logic [1:0] PH_LOW   = 2'd1;
    localparam logic [1:0] PH_VALID = 2'd2;

    typedef enum logic [1:0] {
        S_HIGH   = PH_HIGH,
        S_LOW    = PH_LOW,
        S_VALID  = PH_VALID,
        S_UNUSED = 2'd3
    } state_t;

endpackage

// File: rtl/fpga_switch_loader_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, consecutive-cycle debounce and a
// registered one-cycle pulse on each accepted rising level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             meta_reg;
    logic             sync_reg;
    logic             level_reg;
    logic             level_next;
    logic             level_d_reg;
    logic             rise_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // The counter tracks how long the synced input has disagreed with the
    // accepted level; any agreeing cycle restarts the count.
    always_comb begin
        level_next = level_reg;
        cnt_next   = cnt_reg;
        if (sync_reg == level_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_MAX) begin
            level_next = sync_reg;
            cnt_next   = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg    <= 1'b0;
            sync_reg    <= 1'b0;
            level_reg   <= 1'b0;
            level_d_reg <= 1'b0;
            rise_reg    <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            meta_reg    <= raw;
            sync_reg    <= meta_reg;
            level_reg   <= level_next;
            cnt_reg     <= cnt_next;
            level_d_reg <= level_reg;
            rise_reg    <= level_reg & ~level_d_reg;
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/fpga_switch_loader.sv
// Builds a 32-bit word from two button-confirmed switch halves (high first) and
// offers it to the processor over valid/ready.
module fpga_switch_loader
    import fpga_switch_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HALF_W          = HALF_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [HALF_W-1:0]   sw,
    input  logic                btn,
    input  logic                word_ready,
    output logic                word_valid,
    output logic [2*HALF_W-1:0] word_data,
    output logic [1:0]          phase,
    output logic [HALF_W-1:0]   led_out
);

    logic [HALF_W-1:0]   sw_meta_reg;
    logic [HALF_W-1:0]   sw_sync_reg;
    logic                btn_level;
    logic                press;
    logic                press_ok;
    state_t              state_reg;
    state_t              state_next;
    logic [2*HALF_W-1:0] data_reg;
    logic [2*HALF_W-1:0] data_next;
    logic                valid_reg;
    logic                valid_next;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn),
        .level(btn_level),
        .rise (press)
    );

    // A rise pulse always coincides with a high accepted level.
    assign press_ok = press & btn_level;

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        case (state_reg)
            S_HIGH: begin
                if (press_ok) begin
                    data_next[2*HALF_W-1 -: HALF_W] = sw_sync_reg;
                    state_next = S_LOW;
                end
            end
            S_LOW: begin
                if (press_ok) begin
                    data_next[HALF_W-1:0] = sw_sync_reg;
                    state_next = S_VALID;
                end
            end
            S_VALID: begin
                if (valid_reg && word_ready) begin
                    state_next = S_HIGH;
                end
            end
            default: state_next = S_HIGH;
        endcase
        valid_next = (state_next == S_VALID);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
            state_reg   <= S_HIGH;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
        end else begin
            sw_meta_reg <= sw;
            sw_sync_reg <= sw_meta_reg;
            state_reg   <= state_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
        end
    end

    assign word_valid = valid_reg;
    assign word_data  = data_reg;
    assign phase      = state_reg;
    assign led_out    = sw_sync_reg;

endmodule

// File: tb/tb_fpga_switch_loader.sv
// Directed bench for fpga_switch_loader with a short debounce window.
module tb_fpga_switch_loader;

    localparam int DEB = 4;
    localparam int HW  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [HW-1:0]   sw = '0;
    logic            btn = 1'b0;
    logic            word_ready = 1'b0;
    logic            word_valid;
    logic [2*HW-1:0] word_data;
    logic [1:0]      phase;
    logic [HW-1:0]   led_out;

    int checks = 0;
    int errors = 0;
    int press_cnt = 0;
    int p0 = 0;

    fpga_switch_loader #(
        .DEBOUNCE_CYCLES(DEB),
        .HALF_W         (HW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .btn       (btn),
        .word_ready(word_ready),
        .word_valid(word_valid),
        .word_data (word_data),
        .phase     (phase),
        .led_out   (led_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dut.press) press_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_button(input logic [HW-1:0] v);
        sw = v;
        cycles(3);
        btn = 1'b1;
        cycles(10);
        btn = 1'b0;
        cycles(10);
    endtask

    initial begin
        // Reset state
        cycles(2);
        check("rst_valid", word_valid, 0);
        check("rst_data",  word_data,  0);
        check("rst_phase", phase,      0);
        check("rst_led",   led_out,    0);
        rst = 1'b0;
        cycles(1);

        // 1: two clean presses, press latency of 7 edges
        sw = 16'h1234;
        cycles(3);
        p0 = press_cnt;
        btn = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("t1_press_e%0d", k), dut.press, (k == 7) ? 1 : 0);
        end
        check("t1_phase_low", phase, 1);
        check("t1_data_hi",   word_data, 32'h1234_0000);
        check("t1_valid_lo",  word_valid, 0);
        cycles(2);
        btn = 1'b0;
        cycles(10);
        check("t1_one_pulse", press_cnt - p0, 1);
        press_button(16'hABCD);
        check("t1_valid", word_valid, 1);
        check("t1_data",  word_data,  32'h1234_ABCD);
        check("t1_phase_valid", phase, 2);

        // 3: hold in S_VALID with ready low and an extra press, then transfer
        p0 = press_cnt;
        press_button(16'h5A5A);
        check("t3_pulse_seen", press_cnt - p0, 1);
        check("t3_valid_hold", word_valid, 1);
        check("t3_data_hold",  word_data,  32'h1234_ABCD);
        check("t3_phase_hold", phase, 2);
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        check("t3_valid_drop", word_valid, 0);
        check("t3_phase_back", phase, 0);
        check("t3_data_kept",  word_data, 32'h1234_ABCD);
        cycles(2);
        check("t3_phase_stay", phase, 0);

        // 2: bouncing button then a steady hold gives a single pulse
        sw = 16'h00FF;
        cycles(3);
        p0 = press_cnt;
        for (int i = 0; i < 20; i++) begin
            btn = (((i >> 1) & 1) == 0);
            @(negedge clk);
        end
        check("t2_no_bounce_pulse", press_cnt - p0, 0);
        btn = 1'b1;
        cycles(10);
        btn = 1'b0;
        cycles(15);
        check("t2_one_pulse", press_cnt - p0, 1);
        check("t2_phase", phase, 1);
        check("t2_data_hi_only", word_data, 32'h00FF_ABCD);
        press_button(16'h1111);
        check("t2_data", word_data, 32'h00FF_1111);
        check("t2_valid", word_valid, 1);

        // 4: press pulse in the same cycle as the transfer is ignored
        btn = 1'b1;
        cycles(8);
        check("t4_press_now", dut.press, 1);
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        check("t4_valid", word_valid, 0);
        check("t4_phase", phase, 0);
        check("t4_data",  word_data, 32'h00FF_1111);
        cycles(2);
        btn = 1'b0;
        cycles(10);
        check("t4_phase_stay", phase, 0);

        // 5: asynchronous reset between halves
        press_button(16'h5555);
        check("t5_phase_low", phase, 1);
        check("t5_data_hi", word_data, 32'h5555_1111);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_valid", word_valid, 0);
        check("t5_rst_data",  word_data,  0);
        check("t5_rst_phase", phase,      0);
        check("t5_rst_led",   led_out,    0);
        @(negedge clk);
        rst = 1'b0;
        press_button(16'h0000);
        check("t5_phase_low2", phase, 1);
        press_button(16'hFFFF);
        check("t5_data",  word_data,  32'h0000_FFFF);
        check("t5_valid", word_valid, 1);
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        check("t5_valid_drop", word_valid, 0);

        // 6: long hold, release, and LED echo latency
        sw = 16'h0F0F;
        cycles(3);
        p0 = press_cnt;
        btn = 1'b1;
        cycles(50);
        check("t6_hold_pulse", press_cnt - p0, 1);
        check("t6_phase", phase, 1);
        btn = 1'b0;
        cycles(20);
        check("t6_no_release_pulse", press_cnt - p0, 1);
        check("t6_data_hi", word_data, 32'h0F0F_FFFF);
        sw = 16'hC3A5;
        @(negedge clk);
        check("t6_led_lag", led_out, 16'h0F0F);
        @(negedge clk);
        check("t6_led_new", led_out, 16'hC3A5);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
